// File: rtl/hardtanh_pkg.sv
// hardtanh_pkg
//   Shared types and default widths for the HardTanh job sequencer.
//   state_t  : sequencer state encoding
//   HT_*_W   : default element, address and length widths
package hardtanh_pkg;

  localparam int HT_DATA_W = 32;
  localparam int HT_ADDR_W = 32;
  localparam int HT_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    ABORT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/hardtanh_sched_fifo.sv
// hardtanh_sched_fifo
//   Synchronous show-ahead FIFO holding lane results until memory accepts them.
//   clk, rst_n  : clock, async active-low reset (pointers and count cleared)
//   flush       : drop all entries; wins over push/pop
//   push/push_data : write an entry
//   pop         : retire head entry (ignored when empty)
//   pop_data    : head entry
//   empty/count : occupancy
module hardtanh_sched_fifo
  import hardtanh_pkg::*;
#(
  parameter int DATA_W = HT_DATA_W,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so push into a full FIFO is fine then.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit accounting upstream must make overflow unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/hardtanh_job_sched.sv
// hardtanh_job_sched
//   Sequences one HardTanh job: reads src_base.., feeds the fixed-latency lane,
//   buffers lane results and writes them to dst_base...
//   clk, rst_n                 : clock, async active-low reset
//   cfg_start/cfg_abort        : job start / abort pulses
//   cfg_src_base/cfg_dst_base  : first read / write word address
//   cfg_len, cfg_min, cfg_max  : element count and clamp bounds
//   busy, done, err            : status (done/err are 1-cycle pulses)
//   rd_req/rd_addr/rd_gnt      : read request channel
//   rd_rvalid/rd_rdata         : in-order read return
//   dp_valid_in/dp_data_in     : lane input
//   dp_min/dp_max              : latched clamp bounds for the lane
//   dp_valid_out/dp_data_out   : lane result (no backpressure)
//   wr_req/wr_addr/wr_data/wr_gnt : write request channel
//
//   state | meaning
//   IDLE  | waiting for cfg_start; returning data ignored
//   RUN   | issuing reads under credit, writing results back
//   DRAIN | all reads issued, writing remaining results
//   ABORT | no new requests, FIFO flushed, waiting for in-flight data to drain
//   DONE  | single cycle: done pulse (err too if the job was aborted)
module hardtanh_job_sched
  import hardtanh_pkg::*;
#(
  parameter int DATA_W     = HT_DATA_W,
  parameter int ADDR_W     = HT_ADDR_W,
  parameter int LEN_W      = HT_LEN_W,
  parameter int DP_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DATA_W-1:0] cfg_max,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_rvalid,
  input  logic [DATA_W-1:0] rd_rdata,
  output logic              dp_valid_in,
  output logic [DATA_W-1:0] dp_data_in,
  output logic [DATA_W-1:0] dp_min,
  output logic [DATA_W-1:0] dp_max,
  input  logic              dp_valid_out,
  input  logic [DATA_W-1:0] dp_data_out,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_gnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, issued_q, written_q;
  logic [DATA_W-1:0] min_q, max_q;
  logic [CNT_W-1:0]  inflight_q;
  logic              dpv_q;
  logic [DATA_W-1:0] dpd_q;
  logic              err_q;
  logic              aborted_q;

  logic              start_ok, start_rej;
  logic              bounds_bad;
  logic [DATA_W-1:0] min_key, max_key;
  logic [CNT_W:0]    credit_sum;
  logic              credit_ok;
  logic              rd_fire, wr_fire;
  logic              lane_ret;
  logic              job_live;
  logic              fifo_push, fifo_flush, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Bounds are IEEE bit patterns: map sign-magnitude onto an unsigned order
  // (negatives inverted, positives offset above them) before comparing.
  assign min_key    = cfg_min[DATA_W-1] ? ~cfg_min : {1'b1, cfg_min[DATA_W-2:0]};
  assign max_key    = cfg_max[DATA_W-1] ? ~cfg_max : {1'b1, cfg_max[DATA_W-2:0]};
  assign bounds_bad = (min_key > max_key);

  // inflight counts granted reads until their lane result lands in the FIFO,
  // so the sum below is every result the FIFO may still have to absorb.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok  = (credit_sum < DEPTH_LIM);

  assign job_live = (state_q == RUN) || (state_q == DRAIN);

  assign rd_req  = (state_q == RUN) && (issued_q != len_q) && credit_ok;
  assign rd_addr = src_q + ADDR_W'(issued_q);
  assign rd_fire = rd_req && rd_gnt;

  assign wr_req  = job_live && !fifo_empty;
  assign wr_addr = dst_q + ADDR_W'(written_q);
  assign wr_data = wr_req ? fifo_head : '0;
  assign wr_fire = wr_req && wr_gnt;

  assign lane_ret   = dp_valid_out && (state_q != IDLE) && (inflight_q != '0);
  assign fifo_push  = dp_valid_out && job_live;
  assign fifo_flush = (state_q == ABORT);

  assign dp_valid_in = dpv_q;
  assign dp_data_in  = dpd_q;
  assign dp_min      = min_q;
  assign dp_max      = max_q;
  assign err         = err_q || ((state_q == DONE) && aborted_q);

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    start_rej = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (bounds_bad) begin
            start_rej = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = (cfg_len == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cfg_abort)              state_d = ABORT;
        else if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (cfg_abort)               state_d = ABORT;
        else if (written_q == len_q) state_d = DONE;
      end
      ABORT: begin
        busy = 1'b1;
        if (inflight_q == '0) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_rej;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      issued_q  <= '0;
      written_q <= '0;
      aborted_q <= 1'b0;
    end else if (start_ok) begin
      src_q     <= cfg_src_base;
      dst_q     <= cfg_dst_base;
      len_q     <= cfg_len;
      min_q     <= cfg_min;
      max_q     <= cfg_max;
      issued_q  <= '0;
      written_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (rd_fire) issued_q  <= issued_q + LEN_W'(1);
      if (wr_fire) written_q <= written_q + LEN_W'(1);
      if (state_d == ABORT) aborted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      case ({rd_fire, lane_ret})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Data keeps flowing through the lane during ABORT so inflight can drain;
  // the results are simply not pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpv_q <= 1'b0;
      dpd_q <= '0;
    end else begin
      dpv_q <= rd_rvalid && (state_q != IDLE);
      if (rd_rvalid) dpd_q <= rd_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (FIFO_DEPTH >= DP_LAT + 2);
  end

  hardtanh_sched_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (dp_data_out),
    .pop       (wr_fire),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_hardtanh_job_sched.sv
module tb_hardtanh_job_sched;

  localparam int DP_LAT = 2;
  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;
  localparam logic [31:0] F_P1 = 32'h3F80_0000;
  localparam logic [31:0] F_M1 = 32'hBF80_0000;

  logic        clk, rst_n;
  logic        cfg_start, cfg_abort;
  logic [31:0] cfg_src_base, cfg_dst_base, cfg_min, cfg_max;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic        rd_req, rd_gnt, rd_rvalid;
  logic [31:0] rd_addr, rd_rdata;
  logic        dp_valid_in, dp_valid_out;
  logic [31:0] dp_data_in, dp_min, dp_max, dp_data_out;
  logic        wr_req, wr_gnt;
  logic [31:0] wr_addr, wr_data;

  hardtanh_job_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_len(cfg_len),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
    .rd_rdata(rd_rdata), .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in),
    .dp_min(dp_min), .dp_max(dp_max), .dp_valid_out(dp_valid_out),
    .dp_data_out(dp_data_out), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory / lane responder state
  int          cyc = 0;
  int          rd_lat = 3;
  logic        rd_gnt_en = 1'b1;
  logic        wr_gnt_en = 1'b1;
  int          rq_due[$];
  logic [31:0] rq_dat[$];
  int          lq_due[$];
  logic [31:0] lq_dat[$];

  // per-job observations
  logic [31:0] job_src, job_dst;
  int   grant_cnt, wr_cnt, done_cnt, err_cnt, done_err_cnt, max_occ;
  int   post_abort_req, hold_viol;
  logic busy_seen, rd_seen, wr_seen, abort_armed;
  int   start_cyc, first_rd_cyc, first_rv_cyc, first_wr_cyc, done_cyc;
  logic prev_pending;
  logic [31:0] prev_addr;

  initial begin
    rd_gnt = 1'b0; wr_gnt = 1'b0; rd_rvalid = 1'b0; rd_rdata = '0;
    dp_valid_out = 1'b0; dp_data_out = '0;
    prev_pending = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      rd_rvalid = 1'b0; rd_rdata = '0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        rd_rvalid = 1'b1; rd_rdata = rq_dat[0];
        void'(rq_due.pop_front()); void'(rq_dat.pop_front());
      end
      dp_valid_out = 1'b0; dp_data_out = '0;
      if (lq_due.size() > 0 && lq_due[0] <= cyc) begin
        dp_valid_out = 1'b1; dp_data_out = lq_dat[0];
        void'(lq_due.pop_front()); void'(lq_dat.pop_front());
      end
      rd_gnt = rd_gnt_en;
      wr_gnt = wr_gnt_en;

      if (cfg_start && start_cyc < 0) start_cyc = cyc;
      if (rd_req && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (rd_rvalid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (wr_req && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (dp_valid_in) begin
        lq_due.push_back(cyc + DP_LAT);
        lq_dat.push_back(dp_data_in + 32'd1);
      end
      if (rd_req && rd_gnt) begin
        rq_due.push_back(cyc + rd_lat);
        rq_dat.push_back(rd_addr ^ RD_KEY);
        grant_cnt++;
      end
      if (rst_n && !abort_armed && prev_pending && (!rd_req || rd_addr != prev_addr))
        hold_viol++;
      prev_pending = rd_req && !rd_gnt;
      prev_addr    = rd_addr;
      if (abort_armed && (rd_req || wr_req)) post_abort_req++;
      if (wr_req && wr_gnt) begin
        check_eq("wr_addr", wr_addr, job_dst + 32'(wr_cnt));
        check_eq("wr_data", wr_data, ((job_src + 32'(wr_cnt)) ^ RD_KEY) + 32'd1);
        wr_cnt++;
      end
      if (grant_cnt - wr_cnt > max_occ) max_occ = grant_cnt - wr_cnt;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) done_err_cnt++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy) busy_seen = 1'b1;
      if (rd_req) rd_seen = 1'b1;
      if (wr_req) wr_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    grant_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; done_err_cnt = 0;
    max_occ = 0; post_abort_req = 0; hold_viol = 0;
    busy_seen = 1'b0; rd_seen = 1'b0; wr_seen = 1'b0;
    start_cyc = -1; first_rd_cyc = -1; first_rv_cyc = -1; first_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input logic [31:0] mn, input logic [31:0] mx);
    clear_obs();
    job_src = src; job_dst = dst;
    cfg_src_base = src; cfg_dst_base = dst; cfg_len = len;
    cfg_min = mn; cfg_max = mx;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int target);
    int n = 0;
    while (grant_cnt < target && n < 50) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(grant_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0; cfg_min = '0; cfg_max = '0;
    abort_armed = 1'b0; job_src = '0; job_dst = '0;
    clear_obs();
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_req", 32'(rd_req), 32'd0);
    check_eq("rst_wr_req", 32'(wr_req), 32'd0);
    check_eq("rst_done_err", 32'({done, err, dp_valid_in}), 32'd0);
    check_eq("rst_dp_min", dp_min, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // basic job: len 4, read latency 3
    rd_lat = 3;
    start_job(32'h100, 32'h200, 16'd4, F_M1, F_P1);
    cfg_min = 32'h1234_5678;
    wait_done("t1_done", 100);
    repeat (3) tick();
    check_eq("t1_wr_cnt", 32'(wr_cnt), 32'd4);
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t1_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t1_start_to_rd", 32'(first_rd_cyc - start_cyc), 32'd1);
    check_eq("t1_rv_to_wr", 32'(first_wr_cyc - first_rv_cyc), 32'(1 + DP_LAT + 1));
    check_eq("t1_dp_min", dp_min, F_M1);
    check_eq("t1_dp_max", dp_max, F_P1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // zero length
    start_job(32'h300, 32'h380, 16'd0, F_M1, F_P1);
    wait_done("t2_done", 10);
    repeat (3) tick();
    check_eq("t2_done_lat", 32'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 32'd1);
    check_eq("t2_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t2_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t2_no_req", 32'({rd_seen, wr_seen}), 32'd0);

    // min > max rejected (1.0 > -1.0 in float order)
    start_job(32'h300, 32'h380, 16'd4, F_P1, F_M1);
    repeat (6) tick();
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t3_busy_seen", 32'(busy_seen), 32'd0);
    check_eq("t3_no_req", 32'({rd_seen, wr_seen}), 32'd0);
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd0);

    // write backpressure: 50 cycles without wr_gnt
    rd_lat = 3;
    wr_gnt_en = 1'b0;
    start_job(32'h1000, 32'h2000, 16'd32, F_M1, F_P1);
    repeat (20) tick();
    cfg_min = F_P1; cfg_max = F_M1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    repeat (29) tick();
    check_eq("t4_grants_stalled", 32'(grant_cnt), 32'd8);
    check_eq("t4_occ_hold", 32'(max_occ), 32'd8);
    check_eq("t4_no_writes", 32'(wr_cnt), 32'd0);
    wr_gnt_en = 1'b1;
    wait_done("t4_done", 300);
    repeat (2) tick();
    check_eq("t4_wr_cnt", 32'(wr_cnt), 32'd32);
    check_eq("t4_max_occ", 32'(max_occ), 32'd8);
    check_eq("t4_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t4_rd_hold", 32'(hold_viol), 32'd0);

    // abort after 5 grants, read latency 6
    rd_lat = 6;
    start_job(32'h400, 32'h500, 16'd20, F_M1, F_P1);
    wait_grants("t5_grants", 5);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    abort_armed = 1'b1;
    wait_done("t5_done", 100);
    repeat (3) tick();
    check_eq("t5_done_err", 32'(done_err_cnt), 32'd1);
    check_eq("t5_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t5_post_abort_req", 32'(post_abort_req), 32'd0);
    check_eq("t5_no_writes", 32'(wr_cnt), 32'd0);
    check_eq("t5_busy_end", 32'(busy), 32'd0);
    abort_armed = 1'b0;

    rd_lat = 3;
    start_job(32'h600, 32'h700, 16'd4, F_M1, F_P1);
    wait_done("t6_done", 100);
    repeat (2) tick();
    check_eq("t6_wr_cnt", 32'(wr_cnt), 32'd4);
    check_eq("t6_err_cnt", 32'(err_cnt), 32'd0);

    // reset mid-job with reads outstanding
    rd_lat = 6;
    start_job(32'h800, 32'h900, 16'd8, F_M1, F_P1);
    wait_grants("t7_grants", 3);
    rst_n = 1'b0;
    #1;
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_reqs", 32'({rd_req, wr_req}), 32'd0);
    check_eq("t7_dp_valid_in", 32'(dp_valid_in), 32'd0);
    check_eq("t7_done_err", 32'({done, err}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    clear_obs();
    repeat (20) tick();
    check_eq("t7_late_writes", 32'(wr_cnt), 32'd0);
    check_eq("t7_busy_seen", 32'(busy_seen), 32'd0);
    check_eq("t7_dp_valid_seen", 32'(dp_valid_in), 32'd0);

    // clean job after reset, addresses wrapping past 2^32
    rd_lat = 3;
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFD, 16'd4, F_M1, F_P1);
    wait_done("t8_done", 100);
    repeat (2) tick();
    check_eq("t8_wr_cnt", 32'(wr_cnt), 32'd4);
    check_eq("t8_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t8_done_cnt", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
